jcond_update_sched: RTL

//  Collects resolved conditional-branch outcomes from NPORT branch units (up to NPORT per cycle) and

---
 rtl/jcond_update_sched_pkg.sv | 14 +
 rtl/jcond_fifo.sv | 63 ++++++
 rtl/jcond_update_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/jcond_update_sched_pkg.sv
// Shared defaults and queue-entry field layout for the conditional-branch update scheduler.
package jcond_update_sched_pkg;

    localparam int JQ_XLEN  = 32;
    localparam int JQ_NPORT = 2;
    localparam int JQ_DEPTH = 4;
    localparam int JQ_CNT_W = 8;

    // Entry layout: {pc, hit, taken}
    localparam int JQ_TAKEN_BIT = 0;
    localparam int JQ_HIT_BIT   = 1;
    localparam int JQ_PC_LSB    = 2;

endpackage

// File: rtl/jcond_fifo.sv
// Circular buffer with up to NPORT writes per cycle at caller-supplied offsets from wr_ptr,
// one pop per cycle and an occupancy count. Flush realigns both pointers and empties it.
module jcond_fifo
    import jcond_update_sched_pkg::*;
#(
    parameter int ELEN  = JQ_XLEN + 2,
    parameter int NPORT = JQ_NPORT,
    parameter int DEPTH = JQ_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NPORT-1:0]                    wr_en,
    input  logic [NPORT-1:0][$clog2(DEPTH)-1:0] wr_off,
    input  logic [NPORT-1:0][ELEN-1:0]          wr_data,
    input  logic                                pop,
    input  logic                                flush,
    output logic [ELEN-1:0]                     head,
    output logic [$clog2(DEPTH):0]              q_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [ELEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    n_acc;

    // Number of entries written this cycle.
    always_comb begin
        n_acc = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (wr_en[i]) n_acc = n_acc + CW'(1);
        end
    end

    // Storage array; contents are only observed through head while occupied, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (wr_en[i]) mem[wr_ptr + wr_off[i]] <= wr_data[i];
        end
    end

    // Pointer and occupancy update; pop and push may share an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_acc);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            q_cnt  <= q_cnt - CW'(pop) + n_acc;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/jcond_update_sched.sv
// Serialises up to NPORT resolved conditional branches per cycle into the predictor's single
// update port. Updates are hints: overflow drops the youngest ports and counts them, never stalls.
module jcond_update_sched
    import jcond_update_sched_pkg::*;
#(
    parameter int XLEN  = JQ_XLEN,
    parameter int NPORT = JQ_NPORT,
    parameter int DEPTH = JQ_DEPTH,
    parameter int CNT_W = JQ_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         br_vld,
    input  logic [NPORT*XLEN-1:0]    br_pc,
    input  logic [NPORT-1:0]         br_hit,
    input  logic [NPORT-1:0]         br_taken,
    input  logic                     sched_flush,
    output logic                     jcond_vld,
    output logic [XLEN-1:0]          jcond_pc,
    output logic                     jcond_hit,
    output logic                     jcond_taken,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int ELEN  = XLEN + 2;
    localparam int DW    = $clog2(NPORT + 1);
    localparam int SW    = CNT_W + DW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                             pop;
    logic [CW-1:0]                    free;
    logic [CW-1:0]                    rank;
    logic [NPORT-1:0]                 acc;
    logic [NPORT-1:0][PTR_W-1:0]      off;
    logic [NPORT-1:0][ELEN-1:0]       entry;
    logic [DW-1:0]                    n_drop;
    logic [SW-1:0]                    drop_sum;
    logic [ELEN-1:0]                  head;

    // The predictor always accepts, so any occupied head leaves this cycle.
    assign pop = (q_cnt != '0);

    // Slots available at this edge, counting the one freed by the pop.
    always_comb free = CW'(DEPTH) - q_cnt + CW'(pop);

    // Compact valid ports in port order; the oldest ports win the free slots, the rest are dropped.
    // A flush discards everything incoming without counting it as a drop.
    always_comb begin
        rank   = '0;
        n_drop = '0;
        acc    = '0;
        off    = '0;
        for (int i = 0; i < NPORT; i++) begin
            entry[i] = {br_pc[i*XLEN +: XLEN], br_hit[i], br_taken[i]};
            off[i]   = PTR_W'(rank);
            if (br_vld[i] && !sched_flush) begin
                if (rank < free) begin
                    acc[i] = 1'b1;
                    rank   = rank + CW'(1);
                end else begin
                    n_drop = n_drop + DW'(1);
                end
            end
        end
    end

    jcond_fifo #(
        .ELEN  (ELEN),
        .NPORT (NPORT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc),
        .wr_off  (off),
        .wr_data (entry),
        .pop     (pop),
        .flush   (sched_flush),
        .head    (head),
        .q_cnt   (q_cnt)
    );

    // Widened sum so saturation can be detected before truncation.
    always_comb drop_sum = SW'(drop_cnt) + SW'(n_drop);

    // Saturating drop counter; it holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_sum > SW'(CNT_MAX)) begin
            drop_cnt <= CNT_MAX;
        end else begin
            drop_cnt <= drop_sum[CNT_W-1:0];
        end
    end

    assign jcond_vld   = pop;
    assign jcond_pc    = pop ? head[ELEN-1:JQ_PC_LSB] : '0;
    assign jcond_hit   = pop & head[JQ_HIT_BIT];
    assign jcond_taken = pop & head[JQ_TAKEN_BIT];

endmodule
